// File: rtl/io_pkg.sv
// io_pkg: shared definitions for the memory-mapped I/O port bank.
// Holds the register offsets inside the 32-byte bank window and the
// decoder's register-select enum.
package io_pkg;

   // Byte offsets relative to IO_BASE. The INPORT_i registers sit at INPORT_OFS + 4*i.
   localparam logic [4:0] INPORT_OFS   = 5'h00;
   localparam logic [4:0] STATUS_OFS   = 5'h10;
   localparam logic [4:0] OUTPORT_OFS  = 5'h14;
   localparam logic [4:0] IRQ_MASK_OFS = 5'h18;

   typedef enum logic [2:0] {
      SEL_INPORT,
      SEL_STATUS,
      SEL_OUTPORT,
      SEL_MASK,
      SEL_NONE
   } io_reg_sel_t;

endpackage

// File: rtl/io_port_bank_if.sv
// io_port_bank_if: memory-bus bundle between the datapath and the I/O bank.
//   addr, rd_en, wr_en, wr_data : driven by the datapath (master)
//   rd_data, hit                : driven by the bank (slave)
interface io_port_bank_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] addr;
   logic             rd_en;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rd_data;
   logic             hit;

   modport master (
      output addr, rd_en, wr_en, wr_data,
      input  rd_data, hit
   );

   modport slave (
      input  addr, rd_en, wr_en, wr_data,
      output rd_data, hit
   );
endinterface

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser followed by a counting debouncer.
//   clk, rst   : clock, synchronous active-high reset
//   btn_raw    : raw asynchronous button
//   level      : debounced level
//   rise_pulse : registered one-cycle pulse on each debounced rising edge
module button_debouncer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic rise_pulse
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Once the count has reached the threshold the level flips on the following edge,
   // whatever the input does in that cycle.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
         level_d = ~level_q;
         cnt_d   = '0;
         rise_d  = ~level_q;
      end else if (sync2_q != level_q) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of button-latched input ports, a status
// (new-data) register, an interrupt mask and an output port.
//   clk, rst : clock, synchronous active-high reset
//   buttons  : raw push-buttons, one per input port
//   switches : raw switch levels captured into INPORT_i on a button press
//   bus      : memory bus (slave side); rd_data is registered, hit is combinational
//   outport  : output port register; leds mirror its low bits
//   irq      : registered |(valid & mask)
module io_port_bank
   import io_pkg::*;
#(
   parameter int unsigned      WIDTH           = 32,
   parameter int unsigned      NUM_INPORTS     = 2,
   parameter int unsigned      SW_WIDTH        = 10,
   parameter int unsigned      LED_WIDTH       = 10,
   parameter int unsigned      DEBOUNCE_CYCLES = 4,
   parameter logic [WIDTH-1:0] IO_BASE         = 32'h0000FFE0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_INPORTS-1:0] buttons,
   input  logic [SW_WIDTH-1:0]    switches,
   io_port_bank_if.slave          bus,
   output logic [WIDTH-1:0]       outport,
   output logic [LED_WIDTH-1:0]   leds,
   output logic                   irq
);

   logic [WIDTH-1:0]       offset;
   io_reg_sel_t            sel;
   logic [1:0]             port_idx;
   logic                   hit;
   logic [WIDTH-1:0]       rd_val;
   logic [NUM_INPORTS-1:0] btn_level, btn_rise, cap, rd_port;

   logic [WIDTH-1:0]       inport_q [NUM_INPORTS];
   logic [WIDTH-1:0]       inport_d [NUM_INPORTS];
   logic [NUM_INPORTS-1:0] valid_q, valid_d;
   logic [NUM_INPORTS-1:0] mask_q, mask_d;
   logic [WIDTH-1:0]       outport_q, outport_d;
   logic [WIDTH-1:0]       rd_data_q, rd_data_d;
   logic                   irq_q, irq_d;

   for (genvar g = 0; g < NUM_INPORTS; g++) begin : g_btn
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
         .clk       (clk),
         .rst       (rst),
         .btn_raw   (buttons[g]),
         .level     (btn_level[g]),
         .rise_pulse(btn_rise[g])
      );
   end

   // The pulse is always issued while the level is high; gating keeps a stray pulse
   // from ever capturing once the button has been released.
   assign cap = btn_rise & btn_level;

   // Address decode. IO_BASE is 32-byte aligned, so offset[1:0] equals addr[1:0].
   assign offset   = bus.addr - IO_BASE;
   assign port_idx = offset[3:2];

   always_comb begin
      sel = SEL_NONE;
      if (offset[WIDTH-1:5] == '0 && offset[1:0] == 2'b00) begin
         if (offset[4] == INPORT_OFS[4]) begin
            if (32'(port_idx) < NUM_INPORTS) sel = SEL_INPORT;
         end else begin
            unique case (offset[4:0])
               STATUS_OFS:   sel = SEL_STATUS;
               OUTPORT_OFS:  sel = SEL_OUTPORT;
               IRQ_MASK_OFS: sel = SEL_MASK;
               default:      sel = SEL_NONE;
            endcase
         end
      end
   end

   assign hit = (sel != SEL_NONE);

   always_comb begin
      rd_port = '0;
      for (int i = 0; i < NUM_INPORTS; i++) begin
         rd_port[i] = bus.rd_en && (sel == SEL_INPORT) && (port_idx == 2'(i));
      end
   end

   always_comb begin
      rd_val = '0;
      unique case (sel)
         SEL_INPORT: begin
            for (int i = 0; i < NUM_INPORTS; i++) begin
               if (port_idx == 2'(i)) rd_val = inport_q[i];
            end
         end
         SEL_STATUS:  rd_val = WIDTH'(valid_q);
         SEL_OUTPORT: rd_val = outport_q;
         SEL_MASK:    rd_val = WIDTH'(mask_q);
         default:     rd_val = '0;
      endcase
   end

   // A capture beats a read-clear of the same port so a press is never lost.
   always_comb begin
      inport_d = inport_q;
      valid_d  = valid_q;
      for (int i = 0; i < NUM_INPORTS; i++) begin
         if (cap[i]) begin
            inport_d[i] = WIDTH'(switches);
            valid_d[i]  = 1'b1;
         end else if (rd_port[i]) begin
            valid_d[i] = 1'b0;
         end
      end
      outport_d = outport_q;
      mask_d    = mask_q;
      if (bus.wr_en && sel == SEL_OUTPORT) outport_d = bus.wr_data;
      if (bus.wr_en && sel == SEL_MASK)    mask_d    = bus.wr_data[NUM_INPORTS-1:0];
      rd_data_d = (bus.rd_en && hit) ? rd_val : rd_data_q;
      irq_d     = |(valid_q & mask_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_INPORTS; i++) inport_q[i] <= '0;
         valid_q   <= '0;
         mask_q    <= '0;
         outport_q <= '0;
         rd_data_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         inport_q  <= inport_d;
         valid_q   <= valid_d;
         mask_q    <= mask_d;
         outport_q <= outport_d;
         rd_data_q <= rd_data_d;
         irq_q     <= irq_d;
      end
   end

   assign bus.hit     = hit;
   assign bus.rd_data = rd_data_q;
   assign outport     = outport_q;
   assign leds        = outport_q[LED_WIDTH-1:0];
   assign irq         = irq_q;

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: self-checking bench for io_port_bank. Read expectations are
// queued when a read is issued and compared when rd_data appears one cycle later.
module tb_io_port_bank;

   localparam logic [31:0] BASE = 32'h0000FFE0;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  buttons;
   logic [9:0]  switches;
   logic [31:0] outport;
   logic [9:0]  leds;
   logic        irq;

   io_port_bank_if #(.WIDTH(32)) bus ();

   io_port_bank #(
      .WIDTH          (32),
      .NUM_INPORTS    (2),
      .SW_WIDTH       (10),
      .LED_WIDTH      (10),
      .DEBOUNCE_CYCLES(4),
      .IO_BASE        (BASE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .buttons (buttons),
      .switches(switches),
      .bus     (bus),
      .outport (outport),
      .leds    (leds),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   logic [31:0] exp_q[$];
   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bus cycle issued at a negedge; read data is checked at the following negedge.
   task automatic bus_cycle(input string tag, input logic [31:0] a, input logic rd,
                            input logic wr, input logic [31:0] wd, input logic [31:0] exp_rd);
      logic [31:0] e;
      bus.addr    = a;
      bus.rd_en   = rd;
      bus.wr_en   = wr;
      bus.wr_data = wd;
      if (rd) exp_q.push_back(exp_rd);
      @(negedge clk);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      if (rd) begin
         if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq(tag, bus.rd_data, e);
         end
      end
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      bus_cycle(tag, a, 1'b1, 1'b0, 32'h0, exp);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus_cycle("wr", a, 1'b0, 1'b1, d, 32'h0);
   endtask

   task automatic miss(input string tag, input logic [31:0] a, input logic [31:0] held);
      bus.addr  = a;
      bus.rd_en = 1'b1;
      #1;
      check_eq({tag, "_hit"}, 32'(bus.hit), 32'd0);
      rd({tag, "_rd"}, a, held);
   endtask

   initial begin
      rst         = 1'b1;
      buttons     = '0;
      switches    = '0;
      bus.addr    = '0;
      bus.rd_en   = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = '0;
      wait_cyc(3);
      rst = 1'b0;

      // Reset defaults
      check_eq("rst_rd_data", bus.rd_data, 32'h0);
      check_eq("rst_leds", 32'(leds), 32'h0);
      check_eq("rst_irq", 32'(irq), 32'h0);
      rd("rst_status", BASE + 32'h10, 32'h0);
      rd("rst_outport", BASE + 32'h14, 32'h0);
      rd("rst_mask", BASE + 32'h18, 32'h0);

      // Clean press: first sampled at edge 0, captured at edge 7
      switches   = 10'h2A5;
      buttons[0] = 1'b1;
      wait_cyc(7);
      rd("status_edge7", BASE + 32'h10, 32'h0);
      rd("status_edge8", BASE + 32'h10, 32'h1);
      rd("inport0", BASE + 32'h00, 32'h2A5);
      rd("status_cleared", BASE + 32'h10, 32'h0);
      buttons[0] = 1'b0;
      wait_cyc(12);
      rd("status_release", BASE + 32'h10, 32'h0);

      // Glitch rejection on port 1, then a 6-cycle press that must capture
      switches   = 10'h155;
      buttons[1] = 1'b1;
      wait_cyc(3);
      buttons[1] = 1'b0;
      wait_cyc(12);
      rd("glitch_status", BASE + 32'h10, 32'h0);
      buttons[1] = 1'b1;
      wait_cyc(6);
      buttons[1] = 1'b0;
      wait_cyc(10);
      rd("press6_status", BASE + 32'h10, 32'h2);
      rd("inport1", BASE + 32'h04, 32'h155);
      rd("status_after_rd1", BASE + 32'h10, 32'h0);

      // Outport and leds
      wr(BASE + 32'h14, 32'hDEADB3FF);
      check_eq("outport", outport, 32'hDEADB3FF);
      check_eq("leds", 32'(leds), 32'h3FF);
      rd("outport_rb", BASE + 32'h14, 32'hDEADB3FF);
      wr(BASE + 32'h00, 32'hFFFFFFFF);
      rd("inport0_ro", BASE + 32'h00, 32'h2A5);
      bus_cycle("rw_same", BASE + 32'h14, 1'b1, 1'b1, 32'h12345678, 32'hDEADB3FF);
      rd("outport_new", BASE + 32'h14, 32'h12345678);
      check_eq("leds_new", 32'(leds), 32'h278);

      // Interrupt: mask stores only the port bits
      wr(BASE + 32'h18, 32'hFFFFFFF1);
      rd("mask_rb", BASE + 32'h18, 32'h1);
      check_eq("irq_idle", 32'(irq), 32'h0);
      switches   = 10'h0F0;
      buttons[0] = 1'b1;
      wait_cyc(8);
      check_eq("irq_lag", 32'(irq), 32'h0);
      wait_cyc(1);
      check_eq("irq_set", 32'(irq), 32'h1);
      buttons[0] = 1'b0;
      wait_cyc(12);
      check_eq("irq_held", 32'(irq), 32'h1);

      // Capture on the same edge as a read of INPORT_0
      switches   = 10'h3C3;
      buttons[0] = 1'b1;
      wait_cyc(7);
      rd("cap_vs_rd_old", BASE + 32'h00, 32'h0F0);
      check_eq("cap_vs_rd_irq", 32'(irq), 32'h1);
      rd("cap_vs_rd_valid", BASE + 32'h10, 32'h1);
      check_eq("cap_vs_rd_irq2", 32'(irq), 32'h1);
      rd("cap_vs_rd_new", BASE + 32'h00, 32'h3C3);
      buttons[0] = 1'b0;
      wait_cyc(2);
      check_eq("irq_clear", 32'(irq), 32'h0);

      // Decode boundaries: rd_data must hold the last value read
      miss("miss_1c", BASE + 32'h1C, 32'h3C3);
      miss("miss_02", BASE + 32'h02, 32'h3C3);
      miss("miss_m4", BASE - 32'h4, 32'h3C3);
      miss("miss_08", BASE + 32'h08, 32'h3C3);
      miss("miss_20", BASE + 32'h20, 32'h3C3);
      bus.addr = BASE + 32'h14;
      #1;
      check_eq("hit_14", 32'(bus.hit), 32'h1);
      wait_cyc(1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
